// File: rtl/sin_dds_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : sin_dds_ctrl
//  Purpose  : Direct digital synthesis sequencer for a synchronous sine ROM.
//             Keeps a phase accumulator and a frequency tuning word, drives
//             the ROM address from the top phase bits, captures the ROM read
//             data one cycle later and offers it as a valid/ready stream.
//  Revision : 1.0 - initial release
//
//  Build option:
//    SIN_DDS_ROUND_EN  defined   -> ROM address is the top AW phase bits
//                                   rounded to nearest (wraps to address 0)
//                      undefined -> ROM address is plain truncation
//
//  Ports:
//    clk           in   1            system clock, rising edge
//    rst_n         in   1            asynchronous active-low reset
//    enable        in   1            1 = generate samples continuously
//    cfg_freq      in   PHASE_WIDTH  frequency tuning word
//    cfg_valid     in   1            cfg_freq valid
//    cfg_ready     out  1            always 1 (tuning word always accepted)
//    ROM_addr      out  AW           sine ROM address (combinational from phase)
//    ROM_data      in   ROM_WIDTH    ROM read data, one clk after ROM_addr
//    sample_data   out  ROM_WIDTH    output sample
//    sample_valid  out  1            sample_data valid
//    sample_ready  in   1            consumer accepts sample
//    wrap          out  1            one-cycle pulse after an accumulator overflow
// ============================================================================
module sin_dds_ctrl #(
  parameter int ROM_DEPTH   = 256,
  parameter int ROM_WIDTH   = 12,
  parameter int PHASE_WIDTH = 32,
  localparam int AW         = $clog2(ROM_DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enable,
  input  logic [PHASE_WIDTH-1:0] cfg_freq,
  input  logic                   cfg_valid,
  output logic                   cfg_ready,
  output logic [AW-1:0]          ROM_addr,
  input  logic [ROM_WIDTH-1:0]   ROM_data,
  output logic [ROM_WIDTH-1:0]   sample_data,
  output logic                   sample_valid,
  input  logic                   sample_ready,
  output logic                   wrap
);

  // --------------------------------------------------------------------------
  // State encoding
  // --------------------------------------------------------------------------
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    CAPTURE = 2'd2,
    OUT     = 2'd3
  } state_t;

  state_t                 state;
  state_t                 state_nxt;
  logic [PHASE_WIDTH-1:0] phase;
  logic [PHASE_WIDTH-1:0] freq;
  logic [PHASE_WIDTH:0]   phase_sum;
  logic                   advance;
  logic                   load_sample;

  // The tuning word is accepted unconditionally in every state.
  assign cfg_ready = 1'b1;

  // One extra bit so the carry out of the accumulator is visible for wrap.
  assign phase_sum = {1'b0, phase} + {1'b0, freq};

  // --------------------------------------------------------------------------
  // ROM address: derived from the phase register only, so it is stable for
  // the whole FETCH/CAPTURE/OUT span of a sample.
  // --------------------------------------------------------------------------
`ifdef SIN_DDS_ROUND_EN
  logic [AW-1:0] addr_trunc;
  logic          addr_round;

  assign addr_trunc = phase[PHASE_WIDTH-1 -: AW];
  assign addr_round = phase[PHASE_WIDTH-AW-1];
  // AW-bit addition drops the carry, giving the wrap to address 0.
  assign ROM_addr   = addr_trunc + {{(AW-1){1'b0}}, addr_round};
`else
  assign ROM_addr   = phase[PHASE_WIDTH-1 -: AW];
`endif

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next state and datapath strobes
  // --------------------------------------------------------------------------
  always_comb begin
    state_nxt   = state;
    advance     = 1'b0;
    load_sample = 1'b0;
    case (state)
      IDLE: begin
        if (enable) begin
          state_nxt = FETCH;
        end
      end
      FETCH: begin
        // ROM registers ROM[ROM_addr] at this edge.
        state_nxt = CAPTURE;
      end
      CAPTURE: begin
        // ROM_data now valid; enable is not consulted here so a sample
        // already fetched is always delivered.
        load_sample = 1'b1;
        state_nxt   = OUT;
      end
      OUT: begin
        if (sample_ready) begin
          advance   = 1'b1;
          state_nxt = enable ? FETCH : IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Tuning word. A load coinciding with a phase advance does not affect that
  // advance, because the adder reads the register's current value.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      freq <= '0;
    end else if (cfg_valid) begin
      freq <= cfg_freq;
    end
  end

  // --------------------------------------------------------------------------
  // Phase accumulator and overflow pulse
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase <= '0;
      wrap  <= 1'b0;
    end else begin
      wrap <= 1'b0;
      if (advance) begin
        phase <= phase_sum[PHASE_WIDTH-1:0];
        wrap  <= phase_sum[PHASE_WIDTH];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Sample register. sample_valid is high exactly while in OUT; the data is
  // only written in CAPTURE so it holds under backpressure.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_data  <= '0;
      sample_valid <= 1'b0;
    end else begin
      if (load_sample) begin
        sample_data  <= ROM_data;
        sample_valid <= 1'b1;
      end else if (advance) begin
        sample_valid <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sin_dds_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sin_dds_ctrl
//  Purpose  : Scoreboard bench for sin_dds_ctrl with a ROM model ROM[i]=i.
//             Expected samples are queued by the stimulus; a monitor pops and
//             compares on every accepted sample.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sin_dds_ctrl;

  localparam time T = 10;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [31:0] cfg_freq;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [7:0]  rom_addr;
  logic [11:0] rom_data;
  logic [11:0] sample_data;
  logic        sample_valid;
  logic        sample_ready;
  logic        wrap;

  always #(T/2) clk = ~clk;

  // Synchronous ROM model: data one clock after the address.
  always_ff @(posedge clk) rom_data <= {4'd0, rom_addr};

  sin_dds_ctrl #(
    .ROM_DEPTH   (256),
    .ROM_WIDTH   (12),
    .PHASE_WIDTH (32)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .cfg_freq     (cfg_freq),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .ROM_addr     (rom_addr),
    .ROM_data     (rom_data),
    .sample_data  (sample_data),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .wrap         (wrap)
  );

  logic [11:0] sb[$];
  int n_cmp      = 0;
  int n_err      = 0;
  int hs_count   = 0;
  int wrap_count = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: samples at the falling edge, away from the active edge.
  task automatic monitor();
    logic [11:0] e;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1) begin
        if (wrap === 1'b1) wrap_count++;
        if (sample_valid === 1'b1 && sample_ready === 1'b1) begin
          hs_count++;
          if (sb.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_sample: got 0x%0h, expected none (t=%0t)", sample_data, $time);
          end else begin
            e = sb.pop_front();
            chk("sample", {20'd0, sample_data}, {20'd0, e});
          end
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait until n samples have been accepted; returns just after the
  // accepting edge (DUT then in FETCH or IDLE).
  task automatic wait_hs(input int n);
    int budget = 3000;
    while (hs_count < n && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    if (hs_count < n) begin
      n_cmp++;
      n_err++;
      $display("FAIL wait_hs_timeout: got %0d handshakes, expected %0d", hs_count, n);
    end
    #1;
  endtask

  task automatic wait_valid();
    int budget = 50;
    while (sample_valid !== 1'b1 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (sample_valid !== 1'b1) begin
      n_cmp++;
      n_err++;
      $display("FAIL wait_valid_timeout: got valid=%b, expected 1", sample_valid);
    end
  endtask

  task automatic load_freq(input logic [31:0] f);
    cfg_freq  = f;
    cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic stimulus();
    int  b;
    int  w0;
    time t0;
    time t1;

    // ---------------- reset state ----------------
    repeat (3) tick();
    chk("rst_valid", {31'd0, sample_valid}, 32'd0);
    chk("rst_data",  {20'd0, sample_data},  32'd0);
    chk("rst_addr",  {24'd0, rom_addr},     32'd0);
    chk("rst_wrap",  {31'd0, wrap},         32'd0);
    chk("rst_cfg_ready", {31'd0, cfg_ready}, 32'd1);
    rst_n = 1'b1;
    tick();

    // ---------------- frequency sweep ----------------
    load_freq(32'h0100_0000);
    for (int i = 0; i < 256; i++) sb.push_back(12'(i));
    sb.push_back(12'd0);
    sb.push_back(12'd1);
    enable       = 1'b1;
    sample_ready = 1'b1;
    wait_hs(5);
    t0 = $time;
    wait_hs(6);
    t1 = $time;
    chk("spacing", 32'(t1 - t0), 32'(3 * T));
    chk("cfg_ready_run", {31'd0, cfg_ready}, 32'd1);
    wait_hs(257);
    tick();                       // CAPTURE of sample 1
    enable = 1'b0;
    wait_hs(258);
    repeat (3) tick();
    chk("drop_idle_valid", {31'd0, sample_valid}, 32'd0);
    chk("drop_addr",       {24'd0, rom_addr},     32'd2);
    chk("sweep_wraps",     32'(wrap_count),       32'd1);

    // ---------------- backpressure ----------------
    sb.push_back(12'd2);
    sample_ready = 1'b0;
    enable       = 1'b1;
    wait_valid();
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", {31'd0, sample_valid}, 32'd1);
      chk("bp_data",  {20'd0, sample_data},  32'd2);
      chk("bp_addr",  {24'd0, rom_addr},     32'd2);
      tick();
    end
    b = hs_count;
    sb.push_back(12'd3);
    sb.push_back(12'd4);
    sb.push_back(12'd5);
    sample_ready = 1'b1;
    wait_hs(b + 3);               // 2,3,4 accepted; 5 in flight
    sample_ready = 1'b0;
    wait_valid();
    tick();
    chk("bp2_data", {20'd0, sample_data}, 32'd5);

    // ---------------- retune during OUT handshake ----------------
    sb.push_back(12'd6);
    sb.push_back(12'd10);
    sb.push_back(12'd14);
    cfg_freq     = 32'h0400_0000;
    cfg_valid    = 1'b1;
    sample_ready = 1'b1;
    tick();
    cfg_valid = 1'b0;
    wait_hs(b + 7);               // 5,6,10,14 accepted; now in FETCH

    // ---------------- reset mid-stream, freq = 0 afterwards ----------------
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", {31'd0, sample_valid}, 32'd0);
    chk("midrst_addr",  {24'd0, rom_addr},     32'd0);
    chk("midrst_data",  {20'd0, sample_data},  32'd0);
    for (int i = 0; i < 4; i++) sb.push_back(12'd0);
    w0 = wrap_count;
    b  = hs_count;
    tick();
    rst_n = 1'b1;
    wait_hs(b + 3);
    tick();
    enable = 1'b0;
    wait_hs(b + 4);
    repeat (3) tick();
    chk("f0_wraps", 32'(wrap_count - w0), 32'd0);
    chk("f0_addr",  {24'd0, rom_addr},    32'd0);

    // ---------------- half rate ----------------
    load_freq(32'h8000_0000);
    sb.push_back(12'd0);
    sb.push_back(12'd128);
    sb.push_back(12'd0);
    sb.push_back(12'd128);
    sb.push_back(12'd0);
    w0 = wrap_count;
    b  = hs_count;
    enable = 1'b1;
    wait_hs(b + 4);
    tick();
    enable = 1'b0;
    wait_hs(b + 5);
    repeat (3) tick();
    chk("half_wraps", 32'(wrap_count - w0), 32'd2);

    // ---------------- rounding ----------------
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    load_freq(32'h0080_0000);
`ifdef SIN_DDS_ROUND_EN
    sb.push_back(12'd0); sb.push_back(12'd1); sb.push_back(12'd1);
    sb.push_back(12'd2); sb.push_back(12'd2); sb.push_back(12'd3);
`else
    sb.push_back(12'd0); sb.push_back(12'd0); sb.push_back(12'd1);
    sb.push_back(12'd1); sb.push_back(12'd2); sb.push_back(12'd2);
`endif
    b = hs_count;
    enable = 1'b1;
    wait_hs(b + 5);
    tick();
    enable = 1'b0;
    wait_hs(b + 6);

    // Phase 0xFF800000: round build wraps to address 0.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    load_freq(32'hFF80_0000);
    sb.push_back(12'd0);
    b = hs_count;
    enable = 1'b1;
    tick();                       // FETCH
    enable = 1'b0;
    wait_hs(b + 1);
    repeat (3) tick();
    chk("top_valid", {31'd0, sample_valid}, 32'd0);
`ifdef SIN_DDS_ROUND_EN
    chk("top_addr", {24'd0, rom_addr}, 32'd0);
`else
    chk("top_addr", {24'd0, rom_addr}, 32'd255);
`endif
  endtask

  initial begin
    rst_n        = 1'b0;
    enable       = 1'b0;
    cfg_freq     = 32'd0;
    cfg_valid    = 1'b0;
    sample_ready = 1'b0;
    fork
      monitor();
    join_none
    stimulus();
    repeat (5) tick();
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sin_dds_ctrl.md
Name: sin_dds_ctrl

Overview:
- Direct digital synthesis sequencer for the synchronous sine ROM.
- Holds a phase accumulator and a frequency tuning word, and drives the ROM address.
- Captures the ROM read data, which arrives one cycle after the address, and presents it as a valid/ready sample stream.
- Sits between the sine ROM and downstream consumers (DAC serializer, UART dump, etc.).

Parameters:
- ROM_DEPTH, 256, number of ROM entries; must be a power of two (AW = $clog2(ROM_DEPTH)).
- ROM_WIDTH, 12, ROM data and sample width in bits.
- PHASE_WIDTH, 32, phase accumulator and tuning word width; must be greater than AW.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- enable  in  1  level; 1 = generate samples continuously.
- cfg_freq  in  PHASE_WIDTH  frequency tuning word.
- cfg_valid  in  1  cfg_freq is valid.
- cfg_ready  out  1  controller accepts cfg_freq.
- ROM_addr  out  AW  address to the sine ROM.
- ROM_data  in  ROM_WIDTH  ROM read data; valid one clk after ROM_addr.
- sample_data  out  ROM_WIDTH  output sample.
- sample_valid  out  1  sample_data is valid.
- sample_ready  in  1  consumer accepts the sample.
- wrap  out  1  one-cycle pulse when the phase accumulator overflows.

Behaviour:
- Reset (async assert, sync release) sets these values:
  - state = IDLE, phase = 0, freq = 0.
  - sample_data = 0, sample_valid = 0, wrap = 0, cfg_ready = 1.
  - ROM_addr = 0.
- ROM_addr is combinational from the phase register only: phase[PHASE_WIDTH-1 -: AW].
- Configuration handshake:
  - cfg_ready is 1 in every state.
  - A cycle with cfg_valid=1 loads freq <= cfg_freq at the clock edge.
  - The new freq is first used by the next phase advance; the sample in flight is unaffected.
- State machine:
  - IDLE: sample_valid=0. If enable=1, go to FETCH.
  - FETCH: ROM_addr is stable and the ROM registers ROM[ROM_addr] at the edge. Next state is CAPTURE.
  - CAPTURE: ROM_data is valid. Latch sample_data <= ROM_data and set sample_valid <= 1. Next state is OUT.
  - OUT: sample_valid=1 and sample_data is held stable.
    - On sample_valid & sample_ready: clear sample_valid and set phase <= phase + freq (mod 2^PHASE_WIDTH).
    - Then go to FETCH if enable=1, else IDLE.
    - With no handshake, stay in OUT; phase and sample_data do not change.
- Latency and throughput:
  - FETCH entry to sample_valid=1 is 2 cycles.
  - With sample_ready held at 1, one sample every 3 cycles.
- wrap: asserted for exactly the one cycle after a phase advance whose addition carries out of bit PHASE_WIDTH-1; 0 otherwise.
- enable deasserted in FETCH or CAPTURE: the current sample still completes its OUT handshake, then the block goes to IDLE. The sample is never dropped or truncated.
- freq = 0: the same address is repeated forever; wrap is never asserted.
- cfg_valid coinciding with the OUT handshake: the phase advance uses the old freq; the new freq applies to the following advance.
- rst_n asserted mid-operation: all outputs return to their reset values immediately; the in-flight sample is discarded.
- sample_ready while sample_valid=0 is ignored.

Optional Feature:
- Macro: SIN_DDS_ROUND_EN.
- Defined: ROM_addr = (phase[PHASE_WIDTH-1 -: AW] + phase[PHASE_WIDTH-AW-1]) mod ROM_DEPTH, i.e. round-to-nearest with wrap-around to address 0. Still combinational from phase only.
- Undefined: ROM_addr is plain truncation, as defined above.
- All other behaviour is identical in both builds.

Test Plan (PHASE_WIDTH=32, ROM_DEPTH=256, ROM_WIDTH=12; ROM model with ROM[i]=i):
- Frequency sweep: cfg_freq=0x01000000, enable=1, sample_ready=1 -> samples 0,1,2,…,255,0. Sample spacing is 3 cycles. wrap pulses exactly once, on the advance after sample 255.
- Half-rate: cfg_freq=0x80000000 -> samples alternate 0,128,0,128. wrap pulses on every second advance.
- Backpressure: sample_ready=0 for 5 cycles in OUT -> sample_valid stays 1, sample_data is stable, ROM_addr is unchanged. After sample_ready=1, the next address is old+1 (freq 0x01000000).
- Enable drop: enable=0 during CAPTURE -> the sample is still presented and accepted, then IDLE with sample_valid=0 and phase advanced once. Re-enable resumes from the next address.
- Retune and reset: cfg_freq changes from 0x01000000 to 0x04000000 during OUT -> addresses continue 5,6,10,14. rst_n pulsed low mid-stream -> sample_valid=0, ROM_addr=0 immediately, and samples restart at 0.
- Rounding: cfg_freq=0x00800000 -> addresses 0,0,1,1,2,2 without SIN_DDS_ROUND_EN; 0,1,1,2,2,3 with it. With the macro, phase 0xFF800000 gives ROM_addr 0.
